// File: rtl/addpath_sequencer.sv
// addpath_sequencer: multi-cycle fetch/decode/execute/writeback controller
// for the add-path datapath. It owns the program counter and the retired
// count, and it handshakes with a variable-latency instruction memory.
module addpath_sequencer #(
    parameter int         PC_W     = 14,
    parameter int         PC_STEP  = 4,
    parameter int         RESET_PC = 0,
    parameter logic [2:0] HALT_OP  = 3'b111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [63:0]     imem_rdata,
    output logic [5:0]      rs1,
    output logic [5:0]      rs2,
    output logic [5:0]      rd,
    output logic [2:0]      alu_op,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [PC_W-1:0] PC_INC  = PC_STEP[PC_W-1:0];
    localparam logic [PC_W-1:0] PC_INIT = RESET_PC[PC_W-1:0];

    logic [2:0]      state_r;
    logic [2:0]      state_s;
    logic [63:0]     ir_r;
    logic [PC_W-1:0] pc_r;
    logic            imem_req_r;
    logic [5:0]      rs1_r;
    logic [5:0]      rs2_r;
    logic [5:0]      rd_r;
    logic [2:0]      alu_op_r;
    logic            rf_we_r;
    logic            busy_r;
    logic            halted_r;
    logic [15:0]     retired_r;
    logic            fetch_done_s;
    logic            unused_bits_s;

    // Only the opcode of the stored IR steers control; the upper bits are
    // kept for the datapath view but otherwise unused here.
    assign unused_bits_s = ^{ir_r[63:3], imem_rdata[63:24]};

    // A fetch completes only when the request is actually outstanding.
    assign fetch_done_s = (state_r == ST_FETCH) && imem_ack;

    // Next-state selection for the six-state sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ir_r[2:0] == HALT_OP) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: state_s = ST_WB;
            ST_WB:   state_s = ST_FETCH;
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs, IR capture, PC and retire-count update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ir_r       <= 64'd0;
            pc_r       <= PC_INIT;
            imem_req_r <= 1'b0;
            rs1_r      <= 6'd0;
            rs2_r      <= 6'd0;
            rd_r       <= 6'd0;
            alu_op_r   <= 3'd0;
            rf_we_r    <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            retired_r  <= 16'd0;
        end else begin
            state_r    <= state_s;
            imem_req_r <= (state_s == ST_FETCH);
            busy_r     <= (state_s == ST_FETCH) || (state_s == ST_DECODE) ||
                          (state_s == ST_EXEC)  || (state_s == ST_WB);
            halted_r   <= (state_s == ST_HALT);
            // Register 0 is read-only, so writes to it are suppressed.
            rf_we_r    <= (state_s == ST_WB) && (rd_r != 6'd0);
            if (fetch_done_s) begin
                ir_r     <= imem_rdata;
                rs1_r    <= imem_rdata[17:12];
                rs2_r    <= imem_rdata[23:18];
                rd_r     <= imem_rdata[11:6];
                alu_op_r <= imem_rdata[2:0];
            end
            if (state_r == ST_WB) begin
                pc_r <= pc_r + PC_INC;
                if (retired_r != 16'hFFFF) begin
                    retired_r <= retired_r + 16'd1;
                end
            end
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign rs1       = rs1_r;
    assign rs2       = rs2_r;
    assign rd        = rd_r;
    assign alu_op    = alu_op_r;
    assign rf_we     = rf_we_r;
    assign busy      = busy_r;
    assign halted    = halted_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_addpath_sequencer.sv
// tb_addpath_sequencer: directed sequence with randomized instruction words,
// checked against a small model of pc, retired count and decoded fields.
// A second instance with RESET_PC=16376 shares every input to exercise wrap.
module tb_addpath_sequencer;

    localparam int PC_W    = 14;
    localparam int PC_STEP = 4;
    localparam int WRAP_PC = 16376;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_ack;
    logic [63:0] imem_rdata;

    logic        imem_req, rf_we, busy, halted;
    logic [13:0] imem_addr, pc;
    logic [5:0]  rs1, rs2, rd;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    logic        w_imem_req, w_rf_we, w_busy, w_halted;
    logic [13:0] w_imem_addr, w_pc;
    logic [5:0]  w_rs1, w_rs2, w_rd;
    logic [2:0]  w_alu_op;
    logic [15:0] w_retired;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         m_pc, m_pcw, m_ret;
    logic [5:0] m_rs1, m_rs2, m_rd;
    logic [2:0] m_op;

    addpath_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op),
        .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted),
        .retired(retired)
    );

    addpath_sequencer #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .alu_op(w_alu_op),
        .rf_we(w_rf_we), .pc(w_pc), .busy(w_busy), .halted(w_halted),
        .retired(w_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_rs1"}, rs1, m_rs1);
        chk({tag, "_rs2"}, rs2, m_rs2);
        chk({tag, "_rd"}, rd, m_rd);
        chk({tag, "_op"}, alu_op, m_op);
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_pcw = WRAP_PC;
        m_ret = 0;
        m_rs1 = 6'd0;
        m_rs2 = 6'd0;
        m_rd  = 6'd0;
        m_op  = 3'd0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_wpc"}, w_pc, m_pcw);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_we"}, rf_we, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_retired"}, retired, 16'd0);
        check_fields(tag);
    endtask

    // Called at a negedge; applies reset for one edge (optionally with start high).
    task automatic do_reset(input logic with_start);
        rst_n = 1'b0;
        start = with_start;
        imem_ack = 1'b0;
        @(negedge clk);
        model_reset();
        check_reset("reset");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_req", imem_req, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    // Called at a negedge in IDLE; the request must rise one edge after start.
    task automatic do_start();
        chk("pre_start_req", imem_req, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_req", imem_req, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_addr", imem_addr, m_pc);
    endtask

    // Called at a negedge in the first FETCH cycle of an instruction.
    // mode 0: plain, 1: stray ack in EXEC and stray start in WB, 2: reset in WB.
    task automatic run_instr(input logic [63:0] instr, input int waits, input int mode);
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, m_pc);
            @(negedge clk);
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_pc", pc, m_pc);
        chk("fetch_wpc", w_pc, m_pcw);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = {$urandom, $urandom};
        m_rs1 = instr[17:12];
        m_rs2 = instr[23:18];
        m_rd  = instr[11:6];
        m_op  = instr[2:0];
        check_fields("decode");
        chk("decode_req", imem_req, 1'b0);
        chk("decode_busy", busy, 1'b1);
        chk("decode_we", rf_we, 1'b0);
        if (m_op == 3'b111) begin
            @(negedge clk);
            chk("halt_halted", halted, 1'b1);
            chk("halt_busy", busy, 1'b0);
            chk("halt_we", rf_we, 1'b0);
            chk("halt_pc", pc, m_pc);
            chk("halt_retired", retired, m_ret);
            return;
        end
        @(negedge clk);
        chk("exec_we", rf_we, 1'b0);
        chk("exec_busy", busy, 1'b1);
        chk("exec_req", imem_req, 1'b0);
        if (mode == 1) begin
            imem_ack   = 1'b1;
            imem_rdata = ~instr;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        check_fields("wb");
        chk("wb_we", rf_we, (m_rd != 6'd0));
        chk("wb_pc", pc, m_pc);
        chk("wb_req", imem_req, 1'b0);
        if (mode == 1) start = 1'b1;
        if (mode == 2) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            check_reset("wb_reset");
            return;
        end
        @(negedge clk);
        start = 1'b0;
        m_pc  = (m_pc + PC_STEP) % (1 << PC_W);
        m_pcw = (m_pcw + PC_STEP) % (1 << PC_W);
        m_ret = (m_ret < 65535) ? m_ret + 1 : m_ret;
        chk("next_pc", pc, m_pc);
        chk("next_wpc", w_pc, m_pcw);
        chk("next_retired", retired, m_ret);
        chk("next_wretired", w_retired, m_ret);
        chk("next_req", imem_req, 1'b1);
        chk("next_addr", imem_addr, m_pc);
        chk("next_we", rf_we, 1'b0);
        check_fields("hold");
    endtask

    function automatic logic [63:0] rand_instr(input logic zero_rd);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[2:0] = 3'($urandom_range(0, 6));
        if (zero_rd) v[11:6] = 6'd0;
        else if (v[11:6] == 6'd0) v[11:6] = 6'd1;
        return v;
    endfunction

    logic [63:0] add_i, halt_i;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 64'd0;
        add_i = 64'd0;
        add_i[17:12] = 6'd1;
        add_i[23:18] = 6'd2;
        add_i[11:6]  = 6'd3;
        add_i[2:0]   = 3'd0;
        halt_i = {$urandom, $urandom};
        halt_i[2:0] = 3'b111;
        @(negedge clk);

        // reset wins over a simultaneous start; zero-wait add then halt
        do_reset(1'b1);
        do_start();
        run_instr(add_i, 0, 0);
        run_instr(halt_i, 0, 0);
        chk("prog1_retired", retired, 16'd1);
        chk("prog1_pc", pc, 14'd4);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk("halt_sticky", halted, 1'b1);
        chk("halt_noreq", imem_req, 1'b0);
        chk("halt_nobusy", busy, 1'b0);

        // wait-state fetch
        do_reset(1'b0);
        do_start();
        run_instr(add_i, 5, 0);
        run_instr(halt_i, 2, 0);

        // rd=0 write, random instructions, stray inputs, pc wrap on dut_w
        do_reset(1'b0);
        do_start();
        run_instr(rand_instr(1'b1), 0, 0);
        chk("rd0_retired", retired, 16'd1);
        run_instr(rand_instr(1'b0), $urandom_range(0, 3), 1);
        run_instr(rand_instr(1'b0), $urandom_range(0, 3), 0);
        chk("wrap_wpc", w_pc, 14'd4);
        for (int i = 0; i < 4; i++) begin
            run_instr(rand_instr(i[0]), $urandom_range(0, 3), 1);
        end
        run_instr(halt_i, 0, 0);

        // reset during a fetch wait; a late ack must be ignored
        do_reset(1'b0);
        do_start();
        run_instr(add_i, 0, 0);
        @(negedge clk);
        chk("fw_req", imem_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset("fetch_reset");
        imem_ack = 1'b1;
        imem_rdata = add_i;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_ack_req", imem_req, 1'b0);
        chk("late_ack_busy", busy, 1'b0);
        check_fields("late_ack");

        // reset during WB, then normal operation resumes
        do_start();
        run_instr(rand_instr(1'b0), 1, 2);
        @(negedge clk);
        chk("post_wb_reset_req", imem_req, 1'b0);
        do_start();
        run_instr(add_i, 0, 0);
        run_instr(halt_i, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
